// File: rtl/dialarm_ctrl_pkg.sv
// Shared constants for the UART-driven clock/alarm controller: state codes,
// command characters, ring timeout and small character helpers.
package dialarm_ctrl_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LD_MT = 4'd1;
  localparam logic [3:0] ST_LD_MO = 4'd2;
  localparam logic [3:0] ST_LD_ST = 4'd3;
  localparam logic [3:0] ST_LD_SO = 4'd4;
  localparam logic [3:0] ST_AL_MT = 4'd5;
  localparam logic [3:0] ST_AL_MO = 4'd6;
  localparam logic [3:0] ST_AL_ST = 4'd7;
  localparam logic [3:0] ST_AL_SO = 4'd8;

  localparam logic [7:0] CHR_L   = 8'h4C;
  localparam logic [7:0] CHR_A   = 8'h41;
  localparam logic [7:0] CHR_R   = 8'h52;
  localparam logic [7:0] CHR_S   = 8'h53;
  localparam logic [7:0] CHR_E   = 8'h45;
  localparam logic [7:0] CHR_N   = 8'h4E;
  localparam logic [7:0] CHR_ESC = 8'h1B;
  localparam logic [7:0] CHR_0   = 8'h30;
  localparam logic [7:0] CHR_5   = 8'h35;
  localparam logic [7:0] CHR_9   = 8'h39;

  localparam int RING_TIMEOUT = 30;
  localparam int RING_CNT_W   = 5;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_time_t;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction

  // Tens positions of mm:ss only go up to 5.
  function automatic logic digit_ok(input logic [7:0] c, input logic tens);
    return (c >= CHR_0) && (c <= (tens ? CHR_5 : CHR_9));
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl.sv
// Alarm match detection and ring control: rings on the rising edge of a
// clock/alarm match, stops on silence or after the ring timeout.
module alarm_ring_ctrl
  import dialarm_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      sec_strb,
  input  bcd_time_t clk_time,
  input  bcd_time_t al_time,
  input  logic      alarm_en,
  input  logic      run,
  input  logic      silence,
  output logic      alarm_ring
);

  logic                  match;
  logic                  match_q;
  logic                  trigger;
  logic                  timeout;
  logic [RING_CNT_W-1:0] ring_cnt;

  assign match   = (clk_time == al_time);
  assign trigger = match && !match_q && alarm_en && run;
  assign timeout = alarm_ring && sec_strb &&
                   (ring_cnt == RING_CNT_W'(RING_TIMEOUT - 1));

  // Clearing sources take priority over a trigger in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q    <= 1'b0;
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else begin
      match_q <= match;
      if (silence || timeout) begin
        alarm_ring <= 1'b0;
        ring_cnt   <= '0;
      end else if (trigger && !alarm_ring) begin
        alarm_ring <= 1'b1;
        ring_cnt   <= '0;
      end else if (alarm_ring && sec_strb) begin
        ring_cnt <= ring_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dialarm_ctrl.sv
// UART command parser for a mm:ss clock with alarm: loads clock digits,
// stores alarm digits, and controls run/alarm-enable; ringing lives in alarm_ring_ctrl.
module dialarm_ctrl
  import dialarm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_rdy,
  input  logic [7:0] rx_data,
  input  logic       i_oneSecStrb,
  input  logic [3:0] di_Mtens,
  input  logic [3:0] di_Mones,
  input  logic [3:0] di_Stens,
  input  logic [3:0] di_Sones,
  output logic       dicRun,
  output logic       dicLdMtens,
  output logic       dicLdMones,
  output logic       dicLdStens,
  output logic       dicLdSones,
  output logic [3:0] ld_num,
  output logic [3:0] di_AMtens,
  output logic [3:0] di_AMones,
  output logic [3:0] di_AStens,
  output logic [3:0] di_ASones,
  output logic       alarm_en,
  output logic       alarm_ring,
  output logic       ld_busy
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [7:0] cmd;
  logic       in_idle;
  logic       is_ld;
  logic       tens_pos;
  logic       cmd_acc;
  logic       esc_acc;
  logic       digit_acc;
  logic       run_saved;
  logic       silence;
  bcd_time_t  al_time;
  bcd_time_t  clk_time;

  // rx_data is only looked at on the single cycle rx_data_rdy is high;
  // there is no back-pressure, every strobed character is consumed.
  assign cmd       = to_upper(rx_data);
  assign in_idle   = (state == ST_IDLE);
  assign is_ld     = state inside {[ST_LD_MT:ST_LD_SO]};
  assign tens_pos  = state inside {ST_LD_MT, ST_LD_ST, ST_AL_MT, ST_AL_ST};
  assign cmd_acc   = rx_data_rdy && in_idle;
  assign esc_acc   = rx_data_rdy && !in_idle && (rx_data == CHR_ESC);
  assign digit_acc = rx_data_rdy && !in_idle && (rx_data != CHR_ESC) &&
                     digit_ok(rx_data, tens_pos);
  assign silence   = cmd_acc && ((cmd == CHR_N) || ((cmd == CHR_E) && alarm_en));

  always_comb begin
    state_nxt = state;
    if (cmd_acc) begin
      if (cmd == CHR_L)      state_nxt = ST_LD_MT;
      else if (cmd == CHR_A) state_nxt = ST_AL_MT;
    end else if (esc_acc) begin
      state_nxt = ST_IDLE;
    end else if (digit_acc) begin
      state_nxt = (state == ST_LD_SO || state == ST_AL_SO) ? ST_IDLE
                                                          : state + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ld_busy    <= 1'b0;
      dicRun     <= 1'b0;
      run_saved  <= 1'b0;
      dicLdMtens <= 1'b0;
      dicLdMones <= 1'b0;
      dicLdStens <= 1'b0;
      dicLdSones <= 1'b0;
      ld_num     <= 4'd0;
      al_time    <= '0;
      alarm_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ld_busy    <= (state_nxt != ST_IDLE);
      dicLdMtens <= 1'b0;
      dicLdMones <= 1'b0;
      dicLdStens <= 1'b0;
      dicLdSones <= 1'b0;
      if (cmd_acc) begin
        case (cmd)
          CHR_L: begin
            run_saved <= dicRun;
            dicRun    <= 1'b0;
          end
          CHR_R:   dicRun   <= 1'b1;
          CHR_S:   dicRun   <= 1'b0;
          CHR_E:   alarm_en <= ~alarm_en;
          default: ;
        endcase
      end else if (esc_acc) begin
        // Aborted clock load resumes whatever run state preceded 'L'.
        if (is_ld) dicRun <= run_saved;
      end else if (digit_acc) begin
        case (state)
          ST_LD_MT: begin dicLdMtens <= 1'b1; ld_num <= rx_data[3:0]; end
          ST_LD_MO: begin dicLdMones <= 1'b1; ld_num <= rx_data[3:0]; end
          ST_LD_ST: begin dicLdStens <= 1'b1; ld_num <= rx_data[3:0]; end
          ST_LD_SO: begin
            dicLdSones <= 1'b1;
            ld_num     <= rx_data[3:0];
            dicRun     <= 1'b1;
          end
          ST_AL_MT: al_time.mt <= rx_data[3:0];
          ST_AL_MO: al_time.mo <= rx_data[3:0];
          ST_AL_ST: al_time.st <= rx_data[3:0];
          ST_AL_SO: al_time.so <= rx_data[3:0];
          default:  ;
        endcase
      end
    end
  end

  assign di_AMtens = al_time.mt;
  assign di_AMones = al_time.mo;
  assign di_AStens = al_time.st;
  assign di_ASones = al_time.so;
  assign clk_time  = '{mt: di_Mtens, mo: di_Mones, st: di_Stens, so: di_Sones};

  alarm_ring_ctrl u_ring (
    .clk        (clk),
    .rst        (rst),
    .sec_strb   (i_oneSecStrb),
    .clk_time   (clk_time),
    .al_time    (al_time),
    .alarm_en   (alarm_en),
    .run        (dicRun),
    .silence    (silence),
    .alarm_ring (alarm_ring)
  );

endmodule

// File: tb/tb_dialarm_ctrl.sv
// Bench for dialarm_ctrl: stimulus table, directed alarm/reset sequences and
// random traffic, all compared against a character-level reference model.
module tb_dialarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data_rdy;
  logic [7:0] rx_data;
  logic       i_oneSecStrb;
  logic [3:0] di_Mtens, di_Mones, di_Stens, di_Sones;
  logic       dicRun;
  logic       dicLdMtens, dicLdMones, dicLdStens, dicLdSones;
  logic [3:0] ld_num;
  logic [3:0] di_AMtens, di_AMones, di_AStens, di_ASones;
  logic       alarm_en, alarm_ring, ld_busy;

  always #5 clk = ~clk;

  dialarm_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_rdy  (rx_data_rdy),
    .rx_data      (rx_data),
    .i_oneSecStrb (i_oneSecStrb),
    .di_Mtens     (di_Mtens),
    .di_Mones     (di_Mones),
    .di_Stens     (di_Stens),
    .di_Sones     (di_Sones),
    .dicRun       (dicRun),
    .dicLdMtens   (dicLdMtens),
    .dicLdMones   (dicLdMones),
    .dicLdStens   (dicLdStens),
    .dicLdSones   (dicLdSones),
    .ld_num       (ld_num),
    .di_AMtens    (di_AMtens),
    .di_AMones    (di_AMones),
    .di_AStens    (di_AStens),
    .di_ASones    (di_ASones),
    .alarm_en     (alarm_en),
    .alarm_ring   (alarm_ring),
    .ld_busy      (ld_busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_pass = 0;
  int n_total = 0;

  // mode: 0 idle, 1 loading clock, 2 entering alarm; pos: next digit index
  int m_mode, m_pos, m_ring_secs, m_pulse, m_num;
  bit m_run, m_saved, m_en, m_ring, m_match;
  int m_al[4];
  int c_dig[4];   // clock digits the bench presents to the DUT

  typedef struct {
    bit         rdy;
    logic [7:0] d;
    logic       busy;
    logic       run;
    logic [3:0] ld;
    logic [3:0] num;
    logic [15:0] al;
    logic       en;
  } vec_t;
  vec_t tbl[24];
  logic [7:0] pool[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] act_vec();
    return {4'b0, ld_busy, dicRun, dicLdMtens, dicLdMones, dicLdStens, dicLdSones,
            ld_num, di_AMtens, di_AMones, di_AStens, di_ASones, alarm_en, alarm_ring};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [3:0] p;
    p = 4'b0;
    if (m_pulse >= 0) p[3 - m_pulse] = 1'b1;
    return {4'b0, m_mode != 0, m_run, p, 4'(m_num), 4'(m_al[0]), 4'(m_al[1]),
            4'(m_al[2]), 4'(m_al[3]), m_en, m_ring};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_ring_secs = 0; m_pulse = -1; m_num = 0;
    m_run = 0; m_saved = 0; m_en = 0; m_ring = 0; m_match = 0;
    for (int k = 0; k < 4; k++) m_al[k] = 0;
  endtask

  task automatic model_step(input bit rdy, input logic [7:0] d, input bit strb);
    int ch, lim, t;
    bit match, trig, silence, run_pre;
    ch = int'(d);
    if (ch >= 97 && ch <= 122) ch -= 32;
    run_pre = m_run;
    match   = (c_dig[0] == m_al[0]) && (c_dig[1] == m_al[1]) &&
              (c_dig[2] == m_al[2]) && (c_dig[3] == m_al[3]);
    trig    = match && !m_match && m_en && m_run;
    silence = rdy && m_mode == 0 && (ch == 78 || (ch == 69 && m_en));
    m_match = match;
    if (silence || (m_ring && strb && m_ring_secs + 1 >= 30)) begin
      m_ring = 0; m_ring_secs = 0;
    end else if (trig && !m_ring) begin
      m_ring = 1; m_ring_secs = 0;
    end else if (m_ring && strb) begin
      m_ring_secs++;
    end
    if (strb && run_pre) begin
      t = ((c_dig[0] * 10 + c_dig[1]) * 60 + c_dig[2] * 10 + c_dig[3] + 1) % 3600;
      c_dig[0] = t / 600; c_dig[1] = (t / 60) % 10;
      c_dig[2] = (t % 60) / 10; c_dig[3] = t % 10;
    end
    m_pulse = -1;
    if (rdy) begin
      if (m_mode == 0) begin
        case (ch)
          76: begin m_mode = 1; m_pos = 0; m_saved = m_run; m_run = 0; end
          65: begin m_mode = 2; m_pos = 0; end
          82: m_run = 1;
          83: m_run = 0;
          69: m_en = !m_en;
          default: ;
        endcase
      end else if (d == 8'h1B) begin
        if (m_mode == 1) m_run = m_saved;
        m_mode = 0;
      end else begin
        lim = (m_pos % 2 == 0) ? 53 : 57;
        if (int'(d) >= 48 && int'(d) <= lim) begin
          if (m_mode == 1) begin
            m_pulse = m_pos; m_num = int'(d) - 48; c_dig[m_pos] = int'(d) - 48;
            if (m_pos == 3) m_run = 1;
          end else begin
            m_al[m_pos] = int'(d) - 48;
          end
          m_pos++;
          if (m_pos == 4) m_mode = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_clock();
    di_Mtens = 4'(c_dig[0]); di_Mones = 4'(c_dig[1]);
    di_Stens = 4'(c_dig[2]); di_Sones = 4'(c_dig[3]);
  endtask

  task automatic step(input bit rdy, input logic [7:0] d, input bit strb);
    drive_clock();
    rx_data_rdy = rdy; rx_data = d; i_oneSecStrb = strb;
    @(posedge clk); #1;
    model_step(rdy, d, strb);
    rx_data_rdy = 1'b0; i_oneSecStrb = 1'b0; rx_data = 8'($urandom);
    check("model", act_vec(), exp_vec());
  endtask

  task automatic do_reset(input bit rdy, input logic [7:0] d);
    drive_clock();
    rst = 1'b1; rx_data_rdy = rdy; rx_data = d; i_oneSecStrb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rx_data_rdy = 1'b0;
    model_reset();
    check("reset_zero", act_vec(), 32'h0);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
  endtask

  task automatic send_alarm_to_clock();
    step(1'b1, "A", 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'(48 + c_dig[k]), 1'b0);
  endtask

  task automatic set_row(input int i, input bit rdy, input logic [7:0] d, input logic busy,
                         input logic run, input logic [3:0] ld, input logic [3:0] num,
                         input logic [15:0] al, input logic en);
    tbl[i] = '{rdy, d, busy, run, ld, num, al, en};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; rx_data_rdy = 1'b0; rx_data = 8'h00; i_oneSecStrb = 1'b0;
    for (int k = 0; k < 4; k++) c_dig[k] = 0;
    model_reset();
    drive_clock();
    repeat (3) @(posedge clk);
    #1;
    do_reset(1'b0, 8'h00);

    //          rdy  char   busy run  ld       num   alarm     en
    set_row( 0, 1, "L",   1, 0, 4'b0000, 4'd0, 16'h0000, 0);
    set_row( 1, 1, "1",   1, 0, 4'b1000, 4'd1, 16'h0000, 0);
    set_row( 2, 0, "5",   1, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row( 3, 1, "2",   1, 0, 4'b0100, 4'd2, 16'h0000, 0);
    set_row( 4, 1, "3",   1, 0, 4'b0010, 4'd3, 16'h0000, 0);
    set_row( 5, 1, "4",   0, 1, 4'b0001, 4'd4, 16'h0000, 0);
    set_row( 6, 0, "L",   0, 1, 4'b0000, 4'd4, 16'h0000, 0);
    set_row( 7, 1, "l",   1, 0, 4'b0000, 4'd4, 16'h0000, 0);
    set_row( 8, 1, "7",   1, 0, 4'b0000, 4'd4, 16'h0000, 0);
    set_row( 9, 1, "1",   1, 0, 4'b1000, 4'd1, 16'h0000, 0);
    set_row(10, 0, "2",   1, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(11, 1, 8'h1B, 0, 1, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(12, 1, "s",   0, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(13, 1, "L",   1, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(14, 1, 8'h1B, 0, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(15, 1, "A",   1, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(16, 1, "S",   1, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(17, 1, "6",   1, 0, 4'b0000, 4'd1, 16'h0000, 0);
    set_row(18, 1, "3",   1, 0, 4'b0000, 4'd1, 16'h3000, 0);
    set_row(19, 1, 8'h1B, 0, 0, 4'b0000, 4'd1, 16'h3000, 0);
    set_row(20, 1, "e",   0, 0, 4'b0000, 4'd1, 16'h3000, 1);
    set_row(21, 1, "E",   0, 0, 4'b0000, 4'd1, 16'h3000, 0);
    set_row(22, 1, "x",   0, 0, 4'b0000, 4'd1, 16'h3000, 0);
    set_row(23, 1, "r",   0, 1, 4'b0000, 4'd1, 16'h3000, 0);
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rdy, tbl[i].d, 1'b0);
      check($sformatf("tbl%0d", i), act_vec(),
            {4'b0, tbl[i].busy, tbl[i].run, tbl[i].ld, tbl[i].num, tbl[i].al, tbl[i].en, 1'b0});
    end

    // Alarm at 00:05 with the clock counting from 00:00, then timeout.
    do_reset(1'b0, 8'h00);
    send("L0000");
    send("A0005");
    send("ER");
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1);
    check("ring_pre", 32'(alarm_ring), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("ring_set", 32'(alarm_ring), 32'd1);
    for (int k = 0; k < 29; k++) step(1'b0, 8'h00, 1'b1);
    check("ring_hold29", 32'(alarm_ring), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("ring_timeout", 32'(alarm_ring), 32'd0);

    // 'N' while the match persists: stays silent.
    send_alarm_to_clock();
    step(1'b0, 8'h00, 1'b0);
    check("ring_match", 32'(alarm_ring), 32'd1);
    step(1'b1, "N", 1'b0);
    check("ring_n", 32'(alarm_ring), 32'd0);
    repeat (8) step(1'b0, 8'h00, 1'b0);
    check("ring_stays_off", 32'(alarm_ring), 32'd0);

    // Trigger and 'n' in the same cycle.
    send("A0036");
    send_alarm_to_clock();
    step(1'b1, "n", 1'b0);
    check("trig_n_tie", 32'(alarm_ring), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("trig_n_after", 32'(alarm_ring), 32'd0);

    // 'E' disarming while ringing.
    send("A0036");
    send_alarm_to_clock();
    step(1'b0, 8'h00, 1'b0);
    check("ring_rearm", 32'(alarm_ring), 32'd1);
    step(1'b1, "E", 1'b0);
    check("ring_e_clear", {30'b0, alarm_en, alarm_ring}, 32'd0);

    // Reset mid alarm entry, colliding with a character.
    do_reset(1'b0, 8'h00);
    send("A3");
    do_reset(1'b1, "4");
    step(1'b1, "4", 1'b0);
    check("post_reset_digit", act_vec(), 32'h0);

    // Random traffic against the model.
    pool[0] = "L";  pool[1] = "A";  pool[2] = "R";  pool[3] = "S";
    pool[4] = "E";  pool[5] = "N";  pool[6] = "l";  pool[7] = "a";
    pool[8] = "r";  pool[9] = "s";  pool[10] = "e"; pool[11] = "n";
    pool[12] = 8'h1B; pool[13] = "7"; pool[14] = "9"; pool[15] = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 8'h34);
        continue;
      end
      if ($urandom_range(0, 24) == 0)
        for (int k = 0; k < 4; k++) c_dig[k] = m_al[k];
      if ($urandom_range(0, 3) < 2) d = 8'h30 + 8'($urandom_range(0, 9));
      else d = pool[$urandom_range(0, 15)];
      step(1'($urandom_range(0, 1)), d, $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dialarm_ctrl.md
DIALARM_CTRL -- requirements
Module: dialarm_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock (12 MHz).
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high, sampled on the rising edge of clk.
REQ-003 SHALL have port rx_data_rdy, input, 1, one-cycle strobe: rx_data holds a new UART character.
REQ-004 SHALL have port rx_data, input, 8, ASCII character; valid only while rx_data_rdy=1.
REQ-005 SHALL have port i_oneSecStrb, input, 1, one-cycle strobe, once per second.
REQ-006 SHALL have ports di_Mtens, di_Mones, di_Stens, di_Sones, input, 4 each, current clock digits (BCD).
REQ-007 SHALL have port dicRun, output, 1, 1 means the clock counts.
REQ-008 SHALL have ports dicLdMtens, dicLdMones, dicLdStens, dicLdSones, output, 1 each, one-cycle clock-digit load pulses.
REQ-009 SHALL have port ld_num, output, 4, digit value qualified by any dicLd* pulse.
REQ-010 SHALL have ports di_AMtens, di_AMones, di_AStens, di_ASones, output, 4 each, stored alarm digits.
REQ-011 SHALL have port alarm_en, output, 1, alarm armed.
REQ-012 SHALL have port alarm_ring, output, 1, alarm sounding.
REQ-013 SHALL have port ld_busy, output, 1, FSM not in IDLE.

Function
REQ-014 SHALL accept characters only on cycles where rx_data_rdy=1; commands are case-insensitive.
REQ-015 In IDLE, the FSM SHALL act on these commands: 'L' -> LD_MT and dicRun:=0; 'A' -> AL_MT; 'R' -> dicRun:=1; 'S' -> dicRun:=0; 'E' -> toggle alarm_en; 'N' -> alarm_ring:=0. Any other character SHALL be ignored.
REQ-016 SHALL use this state sequence: LD_MT->LD_MO->LD_ST->LD_SO->IDLE and AL_MT->AL_MO->AL_ST->AL_SO->IDLE, with one valid digit per advance.
REQ-017 SHALL treat a digit as valid when it is ASCII '0'-'5' in the *_MT and *_ST states, and '0'-'9' in the *_MO and *_SO states.
REQ-018 SHALL ignore an invalid character during digit entry: no advance, no pulse.
REQ-019 ESC (8'h1B) in any non-IDLE state SHALL return the FSM to IDLE. Digits already loaded SHALL be kept. dicRun SHALL be restored to its value before 'L'.
REQ-020 On a valid digit in an LD_x state, the matching dicLd* SHALL pulse high for exactly one cycle, in the cycle after rx_data_rdy. ld_num SHALL equal rx_data[3:0] in that same cycle.
REQ-021 After a valid digit is accepted in LD_SO, dicRun SHALL be set to 1.
REQ-022 On a valid digit in an AL_x state, the matching alarm digit register SHALL update in the cycle after rx_data_rdy.
REQ-023 At most one dicLd* SHALL be high in any cycle.
REQ-024 Outside a dicLd* pulse, ld_num SHALL hold its last value.
REQ-025 Match SHALL be defined as: the four clock digits equal the four alarm digits.
REQ-026 alarm_ring SHALL set on the first cycle of match (rising edge of match) when alarm_en=1 and dicRun=1.
REQ-027 A match that persists SHALL NOT re-trigger after 'N'.
REQ-028 alarm_ring SHALL clear on 'N', on 'E' that clears alarm_en, or after 30 i_oneSecStrb pulses counted while ringing (5-bit counter). The timeout SHALL win a tie with the trigger.
REQ-029 If a trigger and an 'N' occur in the same cycle, alarm_ring SHALL end at 0.
REQ-030 Alarm-digit entry SHALL NOT affect dicRun or alarm_ring.
REQ-031 ld_busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-032 On rst=1, the FSM SHALL go to IDLE.
REQ-033 On rst=1, these outputs SHALL clear: dicRun=0, all dicLd*=0, ld_num=0, alarm digits=0, alarm_en=0, alarm_ring=0, ring counter=0, stored match=0.
REQ-034 Reset asserted mid-entry SHALL abort the entry with no further load pulse. Reset SHALL win over a simultaneous rx_data_rdy.

Structure
REQ-035 The state encoding, the ASCII command constants ('L','A','R','S','E','N', ESC) and the ring timeout (30) SHALL live in a shared package.
REQ-036 The match/ring logic SHALL be the single sub-module alarm_ring_ctrl. The parser FSM SHALL stay in the top level.
REQ-037 All outputs SHALL be registered, with no combinational path from rx_data to any output.

Verification
REQ-038 Sending "L","1","2","3","4" SHALL produce dicLdMtens..dicLdSones pulses one character apart, with ld_num=1,2,3,4 respectively. dicRun SHALL be 0 during entry and 1 after '4'.
REQ-039 Sending "L","7","1" SHALL ignore '7', pulse dicLdMtens with ld_num=1, and leave ld_busy=1.
REQ-040 Sending "A","0","0","0","5","E","R" with the clock counting from 00:00 SHALL set alarm_ring at 00:05. With no 'N', alarm_ring SHALL clear after 30 i_oneSecStrb pulses.
REQ-041 Sending 'N' while ringing, with the digits still matching, SHALL clear alarm_ring, and it SHALL stay 0.
REQ-042 Sending "L","1",ESC SHALL return the FSM to IDLE and restore dicRun. Sending 'S' during alarm entry SHALL be treated as an invalid digit and ignored.
REQ-043 Asserting rst after "A","3" SHALL clear all outputs. A following '4' SHALL produce no update.
